// File: rtl/wcd6502_micro_core.sv
// ---------------------------------------------------------------------------
// wcd6502_micro_core
// Decoding micro-core for a 6502 subset (NOP, LDA #imm, PHA, PLA, JMP abs).
// It is a master on a split-data bus. After reset it loads PC from the reset
// vector, then fetches and executes instructions. Rdy stretches any bus cycle.
//
// Ports
//   Clk        in   system clock, rising edge
//   nRst       in   asynchronous active-low reset
//   AB         out  address bus (registered)
//   DB         out  write data, valid while nWR=0
//   nRD / nWR  out  read / write strobes, active low
//   DB_IN      in   read data, sampled at the edge that ends a read cycle
//   Rdy        in   1 = the current bus cycle ends at this edge
//   Sync       out  1 while the current cycle is an opcode fetch
//   Halted     out  sticky flag, set by an illegal opcode or a stack fault
//   Status_SP  out  stack pointer
//   Status_A   out  accumulator
//   Status_PC  out  program counter
//
// Build option
//   WCD_STACK_GUARD_EN : when defined, PHA at SP=00 or PLA at SP=FF halts the
//                        core without a stack access. Otherwise SP wraps.
// ---------------------------------------------------------------------------
module wcd6502_micro_core #(
  parameter int unsigned ADDR_W     = 16,
  parameter logic [15:0] RESET_VEC  = 16'hFFFC,
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [7:0]  SP_INIT    = 8'hFD,
  parameter logic [7:0]  A_INIT     = 8'h00
) (
  input  logic              Clk,
  input  logic              nRst,
  output logic [ADDR_W-1:0] AB,
  output logic [7:0]        DB,
  output logic              nRD,
  output logic              nWR,
  input  logic [7:0]        DB_IN,
  input  logic              Rdy,
  output logic              Sync,
  output logic              Halted,
  output logic [7:0]        Status_SP,
  output logic [7:0]        Status_A,
  output logic [ADDR_W-1:0] Status_PC
);

`ifdef WCD_STACK_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] VEC_LO_ADDR = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] VEC_HI_ADDR = ADDR_W'(RESET_VEC) + ADDR_W'(1'b1);

  typedef enum logic [3:0] {
    ST_BOOT  = 4'd0,
    ST_VEC_L = 4'd1,
    ST_VEC_H = 4'd2,
    ST_FETCH = 4'd3,
    ST_IMM   = 4'd4,
    ST_ABS_L = 4'd5,
    ST_ABS_H = 4'd6,
    ST_PUSH  = 4'd7,
    ST_PULL  = 4'd8,
    ST_HALT  = 4'd9
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        sp_q, sp_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        tmp_q, tmp_d;
  logic [ADDR_W-1:0] ab_q, ab_d;
  logic [7:0]        db_q, db_d;
  logic              nrd_q, nrd_d;
  logic              nwr_q, nwr_d;
  logic              sync_q, sync_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] pc_inc_s;
  logic [7:0]        sp_inc_s;
  logic [7:0]        sp_dec_s;

  // Stack location for a given SP, zero-extended to the bus width.
  function automatic logic [ADDR_W-1:0] stack_addr(input logic [7:0] sp);
    stack_addr = ADDR_W'({STACK_PAGE, sp});
  endfunction

  assign pc_inc_s = pc_q + ADDR_W'(1'b1);
  assign sp_inc_s = sp_q + 8'd1;
  assign sp_dec_s = sp_q - 8'd1;

  // Next-state and next-bus-cycle computation; bus outputs for the following
  // cycle are prepared here and registered at the edge ending this cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    a_d      = a_q;
    tmp_d    = tmp_q;
    ab_d     = ab_q;
    db_d     = db_q;
    nrd_d    = nrd_q;
    nwr_d    = nwr_q;
    sync_d   = sync_q;
    halted_d = halted_q;
    // BOOT is an idle cycle and does not wait for Rdy.
    if (Rdy || (state_q == ST_BOOT)) begin
      ab_d   = {ADDR_W{1'b0}};
      db_d   = 8'h00;
      nrd_d  = 1'b1;
      nwr_d  = 1'b1;
      sync_d = 1'b0;
      case (state_q)
        ST_BOOT: begin
          state_d = ST_VEC_L;
          ab_d    = VEC_LO_ADDR;
          nrd_d   = 1'b0;
        end
        ST_VEC_L: begin
          pc_d    = ADDR_W'(DB_IN);
          state_d = ST_VEC_H;
          ab_d    = VEC_HI_ADDR;
          nrd_d   = 1'b0;
        end
        ST_VEC_H: begin
          pc_d    = ADDR_W'({DB_IN, pc_q[7:0]});
          state_d = ST_FETCH;
          ab_d    = ADDR_W'({DB_IN, pc_q[7:0]});
          nrd_d   = 1'b0;
          sync_d  = 1'b1;
        end
        ST_FETCH: begin
          pc_d = pc_inc_s;
          case (DB_IN)
            8'hEA: begin
              state_d = ST_FETCH;
              ab_d    = pc_inc_s;
              nrd_d   = 1'b0;
              sync_d  = 1'b1;
            end
            8'hA9: begin
              state_d = ST_IMM;
              ab_d    = pc_inc_s;
              nrd_d   = 1'b0;
            end
            8'h4C: begin
              state_d = ST_ABS_L;
              ab_d    = pc_inc_s;
              nrd_d   = 1'b0;
            end
            8'h48: begin
              if (GUARD_EN && (sp_q == 8'h00)) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
              end else begin
                state_d = ST_PUSH;
                ab_d    = stack_addr(sp_q);
                db_d    = a_q;
                nwr_d   = 1'b0;
              end
            end
            8'h68: begin
              if (GUARD_EN && (sp_q == 8'hFF)) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
              end else begin
                state_d = ST_PULL;
                ab_d    = stack_addr(sp_inc_s);
                nrd_d   = 1'b0;
              end
            end
            default: begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end
          endcase
        end
        ST_IMM: begin
          a_d     = DB_IN;
          pc_d    = pc_inc_s;
          state_d = ST_FETCH;
          ab_d    = pc_inc_s;
          nrd_d   = 1'b0;
          sync_d  = 1'b1;
        end
        ST_ABS_L: begin
          tmp_d   = DB_IN;
          pc_d    = pc_inc_s;
          state_d = ST_ABS_H;
          ab_d    = pc_inc_s;
          nrd_d   = 1'b0;
        end
        ST_ABS_H: begin
          pc_d    = ADDR_W'({DB_IN, tmp_q});
          state_d = ST_FETCH;
          ab_d    = ADDR_W'({DB_IN, tmp_q});
          nrd_d   = 1'b0;
          sync_d  = 1'b1;
        end
        ST_PUSH: begin
          sp_d    = sp_dec_s;
          state_d = ST_FETCH;
          ab_d    = pc_q;
          nrd_d   = 1'b0;
          sync_d  = 1'b1;
        end
        ST_PULL: begin
          sp_d    = sp_inc_s;
          a_d     = DB_IN;
          state_d = ST_FETCH;
          ab_d    = pc_q;
          nrd_d   = 1'b0;
          sync_d  = 1'b1;
        end
        ST_HALT: begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
        default: begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
      endcase
    end else begin
      // Wait state: bus, state and registers all hold.
      state_d = state_q;
    end
  end

  // State, architectural registers and registered bus outputs.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= ST_BOOT;
      pc_q     <= {ADDR_W{1'b0}};
      sp_q     <= SP_INIT;
      a_q      <= A_INIT;
      tmp_q    <= 8'h00;
      ab_q     <= {ADDR_W{1'b0}};
      db_q     <= 8'h00;
      nrd_q    <= 1'b1;
      nwr_q    <= 1'b1;
      sync_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      a_q      <= a_d;
      tmp_q    <= tmp_d;
      ab_q     <= ab_d;
      db_q     <= db_d;
      nrd_q    <= nrd_d;
      nwr_q    <= nwr_d;
      sync_q   <= sync_d;
      halted_q <= halted_d;
    end
  end

  assign AB        = ab_q;
  assign DB        = db_q;
  assign nRD       = nrd_q;
  assign nWR       = nwr_q;
  assign Sync      = sync_q;
  assign Halted    = halted_q;
  assign Status_SP = sp_q;
  assign Status_A  = a_q;
  assign Status_PC = pc_q;

endmodule

// File: tb/tb_wcd6502_micro_core.sv
// Self-checking bench for wcd6502_micro_core: directed program table,
// two hand-written multi-cycle sequences and randomized programs checked
// against an instruction-level reference model.
module tb_wcd6502_micro_core;

`ifdef WCD_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        nRst = 1'b0;
  logic        Rdy = 1'b1;
  logic [15:0] AB;
  logic [7:0]  DB;
  logic [7:0]  DB_IN;
  logic        nRD, nWR, Sync, Halted;
  logic [7:0]  Status_SP, Status_A;
  logic [15:0] Status_PC;

  always #5 Clk = ~Clk;

  wcd6502_micro_core dut (
    .Clk(Clk), .nRst(nRst), .AB(AB), .DB(DB), .nRD(nRD), .nWR(nWR),
    .DB_IN(DB_IN), .Rdy(Rdy), .Sync(Sync), .Halted(Halted),
    .Status_SP(Status_SP), .Status_A(Status_A), .Status_PC(Status_PC)
  );

  logic [7:0] mem  [0:65535];   // memory seen by the DUT
  logic [7:0] mmem [0:65535];   // private copy used by the model
  assign DB_IN = mem[AB];

  typedef struct packed {
    logic [15:0] a;
    logic        w;
    logic [7:0]  d;
    logic        s;
  } xact_t;

  xact_t act[$];
  xact_t expq[$];
  int total = 0;
  int bad = 0;
  logic [7:0]  m_a, m_sp;
  logic [15:0] m_pc;
  logic        m_halt;

  typedef struct packed {
    logic [63:0] prog;   // first byte in the top bits
    logic [3:0]  plen;
    logic [47:0] pk_a;   // up to three extra pokes, first in the top bits
    logic [23:0] pk_d;
    logic [1:0]  npk;
    logic [7:0]  nx;     // completed bus cycles to run
    logic [7:0]  ea;
    logic [7:0]  esp;
    logic [15:0] epc;
    logic        eh;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // One clock: log the bus cycle that completes at the coming edge.
  task automatic tick();
    @(negedge Clk);
    if (nRst && Rdy && (!nRD || !nWR)) begin
      act.push_back({AB, !nWR, (!nWR ? DB : 8'h00), Sync});
      if (!nWR) mem[AB] = DB;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic run_until(input int n, input bit rnd);
    int cyc;
    cyc = 0;
    while (act.size() < n && cyc < 4000) begin
      tick();
      cyc++;
      Rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  task automatic do_reset();
    nRst = 1'b0;
    Rdy  = 1'b1;
    tick();
    tick();
    act.delete();
    nRst = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
  endtask

  task automatic sync_model_mem();
    for (int i = 0; i < 65536; i++) mmem[i] = mem[i];
  endtask

  // Instruction-level model: executes the program and lists the bus cycles.
  task automatic model_run(input int max_x);
    logic [15:0] pc;
    logic [7:0]  a, sp, op, lo;
    expq.delete();
    a = 8'h00;
    sp = 8'hFD;
    m_halt = 1'b0;
    expq.push_back({16'hFFFC, 1'b0, 8'h00, 1'b0});
    expq.push_back({16'hFFFD, 1'b0, 8'h00, 1'b0});
    pc = {mmem[16'hFFFD], mmem[16'hFFFC]};
    while (!m_halt && expq.size() < max_x) begin
      op = mmem[pc];
      expq.push_back({pc, 1'b0, 8'h00, 1'b1});
      pc = pc + 16'd1;
      case (op)
        8'hEA: ;
        8'hA9: begin
          expq.push_back({pc, 1'b0, 8'h00, 1'b0});
          a = mmem[pc];
          pc = pc + 16'd1;
        end
        8'h4C: begin
          expq.push_back({pc, 1'b0, 8'h00, 1'b0});
          lo = mmem[pc];
          pc = pc + 16'd1;
          expq.push_back({pc, 1'b0, 8'h00, 1'b0});
          pc = {mmem[pc], lo};
        end
        8'h48: begin
          if (GUARD && sp == 8'h00) m_halt = 1'b1;
          else begin
            expq.push_back({8'h01, sp, 1'b1, a, 1'b0});
            mmem[{8'h01, sp}] = a;
            sp = sp - 8'd1;
          end
        end
        8'h68: begin
          if (GUARD && sp == 8'hFF) m_halt = 1'b1;
          else begin
            sp = sp + 8'd1;
            expq.push_back({8'h01, sp, 1'b0, 8'h00, 1'b0});
            a = mmem[{8'h01, sp}];
          end
        end
        default: m_halt = 1'b1;
      endcase
    end
    m_a = a;
    m_sp = sp;
    m_pc = pc;
  endtask

  task automatic compare_trace(input string tag);
    check($sformatf("%s trace length", tag), act.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < act.size())
        check($sformatf("%s bus cycle %0d {addr,wr,data,sync}", tag, i), act[i], expq[i]);
    end
  endtask

  initial begin
    vecs[0] = '{prog: 64'hA9AA_48A9_5568_0000, plen: 4'd6, pk_a: 48'h0, pk_d: 24'h0, npk: 2'd0,
                nx: 8'd10, ea: 8'hAA, esp: 8'hFD, epc: 16'h8006, eh: 1'b0};
    vecs[1] = '{prog: 64'h4C34_1200_0000_0000, plen: 4'd3, pk_a: 48'h1234_0000_0000, pk_d: 24'hEA0000,
                npk: 2'd1, nx: 8'd6, ea: 8'h00, esp: 8'hFD, epc: 16'h1235, eh: 1'b0};
    vecs[2] = '{prog: 64'h0, plen: 4'd1, pk_a: 48'h0, pk_d: 24'h0, npk: 2'd0,
                nx: 8'd3, ea: 8'h00, esp: 8'hFD, epc: 16'h8001, eh: 1'b1};
`ifdef WCD_STACK_GUARD_EN
    vecs[3] = '{prog: 64'h6868_6848_0000_0000, plen: 4'd4, pk_a: 48'h01FE_01FF_0100, pk_d: 24'h112233,
                npk: 2'd3, nx: 8'd7, ea: 8'h22, esp: 8'hFF, epc: 16'h8003, eh: 1'b1};
`else
    vecs[3] = '{prog: 64'h6868_6848_0000_0000, plen: 4'd4, pk_a: 48'h01FE_01FF_0100, pk_d: 24'h112233,
                npk: 2'd3, nx: 8'd10, ea: 8'h33, esp: 8'hFF, epc: 16'h8004, eh: 1'b0};
`endif
    vecs[4] = '{prog: 64'h4CFE_FF00_0000_0000, plen: 4'd3, pk_a: 48'hFFFE_FFFF_0000, pk_d: 24'hA977EA,
                npk: 2'd3, nx: 8'd8, ea: 8'h77, esp: 8'hFD, epc: 16'h0001, eh: 1'b0};

    // Reset state
    clear_mem();
    tick();
    check("reset AB", AB, 16'h0000);
    check("reset DB", DB, 8'h00);
    check("reset nRD,nWR,Sync,Halted", {nRD, nWR, Sync, Halted}, 4'b1100);
    check("reset SP", Status_SP, 8'hFD);
    check("reset A", Status_A, 8'h00);
    check("reset PC", Status_PC, 16'h0000);

    // Directed program table
    for (int t = 0; t < 5; t++) begin
      clear_mem();
      for (int i = 0; i < vecs[t].plen; i++)
        mem[16'h8000 + i] = vecs[t].prog[63 - 8*i -: 8];
      for (int i = 0; i < vecs[t].npk; i++)
        mem[vecs[t].pk_a[47 - 16*i -: 16]] = vecs[t].pk_d[23 - 8*i -: 8];
      sync_model_mem();
      model_run(vecs[t].nx);
      do_reset();
      run_until(vecs[t].nx, 1'b0);
      if (vecs[t].eh) repeat (10) tick();
      compare_trace($sformatf("vec%0d", t));
      check($sformatf("vec%0d A", t), Status_A, vecs[t].ea);
      check($sformatf("vec%0d SP", t), Status_SP, vecs[t].esp);
      check($sformatf("vec%0d PC", t), Status_PC, vecs[t].epc);
      check($sformatf("vec%0d Halted", t), Halted, vecs[t].eh);
      if (vecs[t].eh) check($sformatf("vec%0d halted strobes", t), {nRD, nWR}, 2'b11);
    end

    // Opcode fetch stretched by three wait states; decode uses the final data
    clear_mem();
    do_reset();
    run_until(2, 1'b0);
    Rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall%0d AB", k), AB, 16'h8000);
      check($sformatf("stall%0d nRD,nWR,Sync,Halted", k), {nRD, nWR, Sync, Halted}, 4'b0110);
    end
    mem[16'h8000] = 8'hEA;
    Rdy = 1'b1;
    tick();
    check("stall release AB", AB, 16'h8001);
    check("stall release PC", Status_PC, 16'h8001);
    check("stall release Sync,Halted", {Sync, Halted}, 2'b10);

    // Reset asserted in the middle of a PHA write cycle
    clear_mem();
    mem[16'h8000] = 8'h48;
    mem[16'h01FD] = 8'h5A;
    do_reset();
    run_until(3, 1'b0);
    check("push cycle strobes", {nRD, nWR}, 2'b10);
    check("push cycle AB", AB, 16'h01FD);
    #2;
    nRst = 1'b0;
    #1;
    check("mid-cycle reset strobes", {nRD, nWR}, 2'b11);
    tick();
    check("aborted write memory", mem[16'h01FD], 8'h5A);
    act.delete();
    nRst = 1'b1;
    run_until(1, 1'b0);
    check("restart first address", (act.size() > 0) ? act[0].a : 16'hxxxx, 16'hFFFC);

    // Randomized programs with random wait states
    for (int r = 0; r < 8; r++) begin
      logic [7:0]  ops [5];
      logic [15:0] vec;
      int          pick;
      ops = '{8'hEA, 8'hA9, 8'h48, 8'h68, 8'h4C};
      for (int i = 0; i < 65536; i++) begin
        pick = $urandom_range(0, 99);
        mem[i] = (pick < 94) ? ops[$urandom_range(0, 4)] : 8'($urandom);
      end
      vec = 16'($urandom);
      mem[16'hFFFC] = vec[7:0];
      mem[16'hFFFD] = vec[15:8];
      sync_model_mem();
      model_run(60);
      do_reset();
      run_until(expq.size(), 1'b1);
      if (m_halt) repeat (10) tick();
      compare_trace($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d A", r), Status_A, m_a);
      check($sformatf("rnd%0d SP", r), Status_SP, m_sp);
      check($sformatf("rnd%0d PC", r), Status_PC, m_pc);
      check($sformatf("rnd%0d Halted", r), Halted, m_halt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
